// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage ARM pipeline.
// Runs the ALU selected by the execute command, keeps the NZCV status
// register, resolves branch targets, and registers results into the EXE/MEM
// boundary for the memory stage.
module exe_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         freeze,
   input  logic         valid_in,
   input  logic [3:0]   exe_cmd,
   input  logic         wb_en_in,
   input  logic         mem_r_en_in,
   input  logic         mem_w_en_in,
   input  logic         b_in,
   input  logic         s_in,
   input  logic [W-1:0] val1,
   input  logic [W-1:0] val2,
   input  logic [W-1:0] st_val_in,
   input  logic [3:0]   dest_in,
   input  logic [W-1:0] pc_in,
   input  logic [23:0]  imm24,
   output logic         branch_taken,
   output logic [W-1:0] branch_addr,
   output logic [3:0]   status,
   output logic         mem_wb_en,
   output logic         mem_r_en,
   output logic         mem_w_en,
   output logic         mem_valid,
   output logic [W-1:0] mem_alu_res,
   output logic [W-1:0] mem_st_val,
   output logic [3:0]   mem_dest
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   logic [3:0]   status_q, status_d;
   logic         wbEn_q, memREn_q, memWEn_q, memValid_q;
   logic [W-1:0] aluRes_q, stVal_q;
   logic [3:0]   dest_q;

   logic [W-1:0] aluRes_d;
   logic [W:0]   sum;
   logic [W-1:0] addB;
   logic         carryIn;
   logic         cFlag, vFlag;

   // ALU: subtraction reuses the adder as val1 + ~val2 + carry-in, so the
   // carry out is directly ARM's NOT-borrow and SBC's carry-in is simply C.
   always_comb begin
      aluRes_d = '0;
      addB     = val2;
      carryIn  = 1'b0;
      sum      = '0;
      cFlag    = status_q[1];
      vFlag    = status_q[0];
      case (exe_cmd)
         CMD_MOV: aluRes_d = val2;
         CMD_MVN: aluRes_d = ~val2;
         CMD_ADD, CMD_ADC: begin
            carryIn  = (exe_cmd == CMD_ADC) ? status_q[1] : 1'b0;
            sum      = {1'b0, val1} + {1'b0, val2} + {{W{1'b0}}, carryIn};
            aluRes_d = sum[W-1:0];
            cFlag    = sum[W];
            vFlag    = (val1[W-1] == val2[W-1]) && (aluRes_d[W-1] != val1[W-1]);
         end
         CMD_SUB, CMD_SBC: begin
            addB     = ~val2;
            carryIn  = (exe_cmd == CMD_SUB) ? 1'b1 : status_q[1];
            sum      = {1'b0, val1} + {1'b0, addB} + {{W{1'b0}}, carryIn};
            aluRes_d = sum[W-1:0];
            cFlag    = sum[W];
            vFlag    = (val1[W-1] != val2[W-1]) && (aluRes_d[W-1] != val1[W-1]);
         end
         CMD_AND: aluRes_d = val1 & val2;
         CMD_ORR: aluRes_d = val1 | val2;
         CMD_EOR: aluRes_d = val1 ^ val2;
         default: aluRes_d = '0;
      endcase
      status_d = {aluRes_d[W-1], (aluRes_d == '0), cFlag, vFlag};
   end

   // Branch target is PC+4 plus the word-scaled signed offset; not frozen.
   always_comb begin
      branch_taken = b_in & valid_in;
      branch_addr  = pc_in + {{(W-26){imm24[23]}}, imm24, 2'b00};
   end

   // Status register: only a real, unstalled flag-setting instruction updates it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= 4'b0000;
      end else if (s_in && valid_in && !freeze) begin
         status_q <= status_d;
      end
   end

   // EXE/MEM register: bubbles clear the control bits, data passes as presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbEn_q     <= 1'b0;
         memREn_q   <= 1'b0;
         memWEn_q   <= 1'b0;
         memValid_q <= 1'b0;
         aluRes_q   <= '0;
         stVal_q    <= '0;
         dest_q     <= '0;
      end else if (!freeze) begin
         wbEn_q     <= wb_en_in & valid_in;
         memREn_q   <= mem_r_en_in & valid_in;
         memWEn_q   <= mem_w_en_in & valid_in;
         memValid_q <= valid_in;
         aluRes_q   <= aluRes_d;
         stVal_q    <= st_val_in;
         dest_q     <= dest_in;
      end
   end

   assign status      = status_q;
   assign mem_wb_en   = wbEn_q;
   assign mem_r_en    = memREn_q;
   assign mem_w_en    = memWEn_q;
   assign mem_valid   = memValid_q;
   assign mem_alu_res = aluRes_q;
   assign mem_st_val  = stVal_q;
   assign mem_dest    = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage with a behavioural ALU/flag model.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        freeze = 1'b0, valid_in = 1'b0;
   logic [3:0]  exe_cmd = '0;
   logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
   logic        b_in = 1'b0, s_in = 1'b0;
   logic [31:0] val1 = '0, val2 = '0, st_val_in = '0, pc_in = '0;
   logic [3:0]  dest_in = '0;
   logic [23:0] imm24 = '0;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [3:0]  status;
   logic        mem_wb_en, mem_r_en, mem_w_en, mem_valid;
   logic [31:0] mem_alu_res, mem_st_val;
   logic [3:0]  mem_dest;

   typedef struct {
      logic        wb, rd, wr, valid;
      logic [31:0] res, st;
      logic [3:0]  dest, status;
   } exp_t;

   exp_t expQ[$];
   exp_t last;
   logic [3:0] modelStatus;
   int checks = 0;
   int failures = 0;

   exe_stage #(.W(32)) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .valid_in(valid_in),
      .exe_cmd(exe_cmd), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in),
      .val1(val1), .val2(val2), .st_val_in(st_val_in), .dest_in(dest_in),
      .pc_in(pc_in), .imm24(imm24),
      .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
      .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .mem_valid(mem_valid), .mem_alu_res(mem_alu_res),
      .mem_st_val(mem_st_val), .mem_dest(mem_dest)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Single comparison point: every check steps the counters here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU: plain wide arithmetic and range checks on the operands.
   function automatic void aluModel(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] st, output logic [31:0] res, output logic [3:0] nst);
      longint ua, ub, sa, sb, t;
      logic c, v;
      int k;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c = st[1];
      v = st[0];
      res = '0;
      case (cmd)
         4'b0001: res = b;
         4'b1001: res = ~b;
         4'b0010, 4'b0011: begin
            k = (cmd == 4'b0011 && st[1]) ? 1 : 0;
            t = ua + ub + longint'(k);
            res = t[31:0];
            c = (t >= 64'sd4294967296);
            t = sa + sb + longint'(k);
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'b0100, 4'b0101: begin
            k = (cmd == 4'b0101 && !st[1]) ? 1 : 0;
            t = ua - ub - longint'(k);
            res = t[31:0];
            c = (ua >= ub + longint'(k));
            t = sa - sb - longint'(k);
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'b0110: res = a & b;
         4'b0111: res = a | b;
         4'b1000: res = a ^ b;
         default: res = '0;
      endcase
      nst = {res[31], (res == 32'd0), c, v};
   endfunction

   // Drive one cycle of ID/EXE inputs, check branch outputs, predict EXE/MEM.
   task automatic applyStimulus(input logic fz, input logic vld, input logic [3:0] cmd,
                                input logic wb, input logic rd, input logic wr,
                                input logic br, input logic s,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] stv,
                                input logic [3:0] dst, input logic [31:0] pc, input logic [23:0] imm);
      exp_t e;
      logic [31:0] res;
      logic [3:0] nst;
      int off;
      freeze = fz; valid_in = vld; exe_cmd = cmd;
      wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr; b_in = br; s_in = s;
      val1 = a; val2 = b; st_val_in = stv; dest_in = dst; pc_in = pc; imm24 = imm;
      #1;
      off = imm[23] ? (int'(imm) - 16777216) : int'(imm);
      checkOutput("branch_taken", {31'd0, branch_taken}, {31'd0, (br && vld)});
      checkOutput("branch_addr", branch_addr, pc + 32'(off * 4));
      aluModel(cmd, a, b, modelStatus, res, nst);
      @(posedge clk);
      if (!fz) begin
         if (vld && s) modelStatus = nst;
         e.wb = wb & vld; e.rd = rd & vld; e.wr = wr & vld; e.valid = vld;
         e.res = res; e.st = stv; e.dest = dst;
         last = e;
      end
      e = last;
      e.status = modelStatus;
      expQ.push_back(e);
      #1;
   endtask

   // Asynchronous reset check: outputs must clear before any clock edge.
   task automatic applyReset();
      expQ.delete();
      rst_n = 1'b0;
      #1;
      checkOutput("reset_status", {28'd0, status}, 32'd0);
      checkOutput("reset_ctrl", {28'd0, mem_wb_en, mem_r_en, mem_w_en, mem_valid}, 32'd0);
      checkOutput("reset_alu_res", mem_alu_res, 32'd0);
      checkOutput("reset_st_val", mem_st_val, 32'd0);
      checkOutput("reset_dest", {28'd0, mem_dest}, 32'd0);
      modelStatus = 4'b0000;
      last = '{wb: 1'b0, rd: 1'b0, wr: 1'b0, valid: 1'b0, res: '0, st: '0, dest: '0, status: '0};
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   // Monitor: pops one prediction per captured edge and compares on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("status", {28'd0, status}, {28'd0, e.status});
         checkOutput("mem_ctrl", {28'd0, mem_wb_en, mem_r_en, mem_w_en, mem_valid},
                     {28'd0, e.wb, e.rd, e.wr, e.valid});
         if (e.valid) begin
            checkOutput("mem_alu_res", mem_alu_res, e.res);
            checkOutput("mem_st_val", mem_st_val, e.st);
            checkOutput("mem_dest", {28'd0, mem_dest}, {28'd0, e.dest});
         end
      end
   end

   function automatic logic [31:0] randOp();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [3:0] cmds [0:9];
      cmds = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1111};
      #7;
      applyReset();

      // ADDS wrap to zero, then ADC picks up the fresh carry.
      applyStimulus(0, 1, 4'b0010, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd1, 32'h0, 24'h0);
      applyStimulus(0, 1, 4'b0011, 1, 0, 0, 0, 0, 32'd5, 32'd6, 32'h0, 4'd2, 32'h0, 24'h0);
      // SUBS overflow, CMP with borrow, SBC with C=0 and C=1, ORRS keeps C/V.
      applyStimulus(0, 1, 4'b0100, 1, 0, 0, 0, 1, 32'h8000_0000, 32'h1, 32'h0, 4'd3, 32'h0, 24'h0);
      applyStimulus(0, 1, 4'b0100, 0, 0, 0, 0, 1, 32'd3, 32'd5, 32'h0, 4'd4, 32'h0, 24'h0);
      applyStimulus(0, 1, 4'b0101, 1, 0, 0, 0, 0, 32'd10, 32'd3, 32'h0, 4'd5, 32'h0, 24'h0);
      applyStimulus(0, 1, 4'b0100, 1, 0, 0, 0, 1, 32'd5, 32'd3, 32'h0, 4'd6, 32'h0, 24'h0);
      applyStimulus(0, 1, 4'b0101, 1, 0, 0, 0, 0, 32'd10, 32'd3, 32'h0, 4'd7, 32'h0, 24'h0);
      applyStimulus(0, 1, 4'b0100, 1, 0, 0, 0, 1, 32'h8000_0000, 32'h1, 32'h0, 4'd3, 32'h0, 24'h0);
      applyStimulus(0, 1, 4'b0111, 1, 0, 0, 0, 1, 32'h0F, 32'hF0, 32'h0, 4'd8, 32'h0, 24'h0);
      // Branch taken backwards, then the same branch as a bubble.
      applyStimulus(0, 1, 4'b0000, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'd0, 32'h100, 24'hFFFFFE);
      applyStimulus(0, 0, 4'b0000, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 4'd0, 32'h100, 24'hFFFFFE);
      // STR, then LDR held by a three-cycle freeze with s_in set.
      applyStimulus(0, 1, 4'b0010, 0, 0, 1, 0, 0, 32'h20, 32'h4, 32'hDEAD_BEEF, 4'd9, 32'h0, 24'h0);
      repeat (3)
         applyStimulus(1, 1, 4'b0010, 1, 1, 0, 0, 1, 32'h40, 32'h8, 32'h0, 4'd10, 32'h0, 24'h0);
      applyStimulus(0, 1, 4'b0010, 1, 1, 0, 0, 1, 32'h40, 32'h8, 32'h0, 4'd10, 32'h0, 24'h0);

      // Randomized traffic with a reset dropped into the middle of it.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) applyReset();
         applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0),
                       cmds[$urandom_range(0, 9)],
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       randOp(), randOp(), $urandom, 4'($urandom), $urandom, 24'($urandom));
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage ARM pipeline, directly downstream of the ID-stage control unit and its ID/EXE register. It runs the ALU selected by the 4-bit execute command and holds the NZCV status register, updated only by flag-setting instructions. It also resolves branch targets and registers results into the EXE/MEM boundary for the memory stage.

## Interface
- W, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- freeze  in  1  hazard stall; holds EXE/MEM register and status
- valid_in  in  1  instruction in EXE is real (0 = bubble)
- exe_cmd  in  4  ALU op: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; others → result 0
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control from ID/EXE
- val1  in  W  Rn operand
- val2  in  W  shifter operand / offset
- st_val_in  in  W  Rd value for STR
- dest_in  in  4  destination register number
- pc_in  in  W  PC of instruction + 4
- imm24  in  24  branch offset field
- branch_taken  out  1  combinational: b_in & valid_in
- branch_addr  out  W  combinational: pc_in + (sign-extended imm24 << 2), mod 2^W
- status  out  4  registered NZCV ({N,Z,C,V}, bit 3 = N)
- mem_wb_en, mem_r_en, mem_w_en, mem_valid  out  1 each  registered control
- mem_alu_res, mem_st_val  out  W  registered result / store data
- mem_dest  out  4  registered destination

## Operation
- ALU (combinational, W-bit, two's complement), C = status[1]:
  - MOV: val2; MVN: ~val2
  - ADD: val1+val2; ADC: val1+val2+C
  - SUB: val1−val2; SBC: val1−val2−(~C & 1)
  - AND/ORR/EOR: bitwise
- Flags computed: N = res[W−1]; Z = (res == 0)
  - ADD/ADC: C = carry out of bit W−1; V = operands same sign and result sign differs
  - SUB/SBC: C = NOT borrow (1 when val1 ≥ val2 + borrow, unsigned); V = operand signs differ and result sign ≠ val1 sign
  - logic/MOV/MVN: C, V unchanged
- Status update: at clock edge when s_in & valid_in & ~freeze; else hold.
- CMP/TST arrive as SUB/AND with wb_en_in = 0, s_in = 1: flags only.
- LDR/STR arrive as ADD: address = val1 + val2, forwarded as mem_alu_res.
- Branch: branch_taken/branch_addr are combinational, not gated by freeze; the fetch stage and hazard unit own the flush response.
- Bubble (valid_in = 0): EXE/MEM captures wb/mem_r/mem_w/valid = 0; data fields don't-care (captured as presented); status holds.

## Timing
- Reset (rst_n low, asynchronous): status = 0000; mem_wb_en = mem_r_en = mem_w_en = mem_valid = 0; mem_alu_res = mem_st_val = 0; mem_dest = 0. Release synchronous to next edge; first capture at first rising edge with rst_n high.
- Latency: 1 cycle from ID/EXE inputs to EXE/MEM outputs; status visible the cycle after the flag-setting instruction.
- Back-to-back: ADDS then ADC in next cycle uses the updated C (no bypass needed).
- freeze = 1: all registered outputs and status hold; ALU and branch outputs still track inputs.
- freeze and s_in in the same cycle: no status update; update occurs when freeze drops with instruction still presented.
- Reset asserted mid-stall or mid-instruction: outputs go to reset values immediately; in-flight instruction is lost.
- Adder wrap: results modulo 2^W; carry/overflow only reported via flags.

## Test plan
- Reset: hold rst_n low mid-run with nonzero state → status = 0000, all mem_* = 0 asynchronously, before next edge.
- ADDS 0xFFFFFFFF + 0x00000001 (s_in = 1) → mem_alu_res = 0, next status = 0110 (Z, C); then ADC 5 + 6 → mem_alu_res = 12.
- SUBS 0x80000000 − 1 → res 0x7FFFFFFF, status = 0011 (C = 1, V = 1); CMP 3 vs 5 → status = 1000, mem_wb_en = 0.
- SBC 10 − 3 with C = 0 → 6; with C = 1 → 7; ORR with s_in = 1 after C = 1, V = 1 → C, V preserved.
- Branch: pc_in = 0x100, imm24 = 0xFFFFFE, b_in = 1 → branch_taken = 1, branch_addr = 0x0F8 same cycle; valid_in = 0 → branch_taken = 0.
- freeze for 3 cycles during LDR (val1 = 0x40, val2 = 8) with s_in = 1 on the held instruction → mem_* hold previous values, status unchanged; on release mem_alu_res = 0x48, mem_r_en = 1.
